// File: rtl/hms_timer_if.sv
// Control and display bundle between the board top and the hms time base.
// Signalling contract: there is no valid/ready pair. Every control input except set_btn is a
// level sampled on each rising CLOCK_50; set_btn is a raw asynchronous button. All outputs are registered.
interface hms_timer_if;
  logic       clear;
  logic       mode;
  logic       run;
  logic       set_btn;
  logic [1:0] set_field;
  logic       set_dir;
  logic       lap;
  logic [6:0] seconds;
  logic [6:0] minutes;
  logic [6:0] hours;
  logic       running;
  logic       done;
  logic       tick;

  modport master (
    output clear, mode, run, set_btn, set_field, set_dir, lap,
    input  seconds, minutes, hours, running, done, tick
  );

  modport slave (
    input  clear, mode, run, set_btn, set_field, set_dir, lap,
    output seconds, minutes, hours, running, done, tick
  );
endinterface

// File: rtl/hms_timer_core.sv
// Hours/minutes/seconds stopwatch and countdown time base with preset editing,
// lap freeze and sticky done flag, driven by an internal tick prescaler.
module hms_timer_core #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int HOUR_MAX = 99
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  hms_timer_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int              TERM   = CLK_HZ / TICK_HZ - 1;
  localparam int              PW     = $clog2(TERM + 1);
  localparam logic [PW-1:0]   TERM_V = PW'(TERM);
  localparam logic [6:0]      HMAX   = 7'(HOUR_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] h;
    logic [6:0] m;
    logic [6:0] s;
  } hms_t;

  function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max);
    return (v == max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] dec_wrap(input logic [6:0] v, input logic [6:0] max);
    return (v == 7'd0) ? max : v - 7'd1;
  endfunction

  function automatic hms_t edit_preset(input hms_t p, input logic [1:0] f, input logic up);
    hms_t r;
    r = p;
    case (f)
      2'b00:   r.s = up ? inc_wrap(p.s, 7'd59) : dec_wrap(p.s, 7'd59);
      2'b01:   r.m = up ? inc_wrap(p.m, 7'd59) : dec_wrap(p.m, 7'd59);
      2'b10:   r.h = up ? inc_wrap(p.h, HMAX) : dec_wrap(p.h, HMAX);
      default: r = p;
    endcase
    return r;
  endfunction

  // Hours wrapping past HOUR_MAX naturally returns the whole counter to zero.
  function automatic hms_t count_up(input hms_t c);
    hms_t r;
    r   = c;
    r.s = inc_wrap(c.s, 7'd59);
    if (c.s == 7'd59) begin
      r.m = inc_wrap(c.m, 7'd59);
      if (c.m == 7'd59) r.h = inc_wrap(c.h, HMAX);
    end
    return r;
  endfunction

  function automatic hms_t count_down(input hms_t c);
    hms_t r;
    r   = c;
    r.s = dec_wrap(c.s, 7'd59);
    if (c.s == 7'd0) begin
      r.m = dec_wrap(c.m, 7'd59);
      if (c.m == 7'd0) r.h = c.h - 7'd1;
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  hms_t          preset_q, preset_d;
  hms_t          cnt_q, cnt_d;
  hms_t          disp_q, disp_d;
  hms_t          src;
  hms_t          cnt_dn;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sync_q, sync_d;
  logic          mode_q, mode_d;
  logic          lap_q, lap_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;
  logic          set_evt;
  logic          tick_evt;

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    sync_d   = {sync_q[1:0], bus.set_btn};
    set_evt  = sync_q[1] & ~sync_q[2];
    tick_evt = (state_q == S_RUN) && (presc_q == TERM_V);
    cnt_dn   = count_down(cnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_RUN;
          mode_d  = bus.mode;
          cnt_d   = bus.mode ? preset_q : '0;
          presc_d = '0;
        end else if (set_evt) begin
          preset_d = edit_preset(preset_q, bus.set_field, bus.set_dir);
        end
      end
      S_RUN: begin
        presc_d = tick_evt ? '0 : presc_q + PW'(1);
        // A countdown that starts at zero finishes immediately without a tick.
        if (mode_q && (cnt_q == '0)) begin
          state_d = S_DONE;
        end else begin
          if (tick_evt) begin
            tick_d = 1'b1;
            if (mode_q) begin
              cnt_d = cnt_dn;
              if (cnt_dn == '0) state_d = S_DONE;
            end else begin
              cnt_d = count_up(cnt_q);
            end
          end
          if ((state_d == S_RUN) && !bus.run) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.run) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
    endcase

    if (bus.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      presc_d = '0;
      tick_d  = 1'b0;
    end

    src       = (state_q == S_IDLE) ? (bus.mode ? preset_q : '0) : cnt_q;
    lap_d     = bus.lap;
    disp_d    = (bus.lap && lap_q) ? disp_q : src;
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      preset_q  <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      presc_q   <= '0;
      sync_q    <= '0;
      mode_q    <= 1'b0;
      lap_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      sync_q    <= sync_d;
      mode_q    <= mode_d;
      lap_q     <= lap_d;
      running_q <= running_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.seconds = disp_q.s;
  assign bus.minutes = disp_q.m;
  assign bus.hours   = disp_q.h;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.tick    = tick_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_hms_timer_core.sv
// Directed-plus-random bench for hms_timer_core with CLK_HZ=10 so one tick every 10 cycles.
module tb_hms_timer_core;
  localparam int CLK_HZ   = 10;
  localparam int TICK_HZ  = 1;
  localparam int HOUR_MAX = 99;
  localparam int TP       = CLK_HZ / TICK_HZ;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  hms_timer_if tif ();

  hms_timer_core #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .HOUR_MAX(HOUR_MAX)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (tif),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          tick_cnt = 0;
  int          last_tick = -1;
  bit          spacing_on = 1'b0;
  logic [20:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (tif.tick === 1'b1) begin
      if (spacing_on && (last_tick >= 0)) chk("tick_spacing", cyc - last_tick, TP);
      last_tick = cyc;
      tick_cnt++;
    end
  end

  // Reference: total seconds converted to the h:m:s display triple.
  function automatic logic [20:0] hms(input int t);
    int h, m, s;
    h = (t / 3600) % (HOUR_MAX + 1);
    m = (t / 60) % 60;
    s = t % 60;
    return {7'(h), 7'(m), 7'(s)};
  endfunction

  function automatic logic [20:0] disp();
    return {tif.hours, tif.minutes, tif.seconds};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_event(input logic [1:0] f, input logic d);
    tif.set_field = f;
    tif.set_dir   = d;
    tif.set_btn   = 1'b1;
    step(4);
    tif.set_btn   = 1'b0;
    step(3);
  endtask

  task automatic do_clear();
    tif.clear = 1'b1;
    step(1);
    tif.clear = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    int t0, k, acc, n, h, f, d;
    int ps, pm, ph;

    reset         = 1'b1;
    tif.clear     = 1'b0;
    tif.mode      = 1'b0;
    tif.run       = 1'b0;
    tif.set_btn   = 1'b0;
    tif.set_field = 2'b00;
    tif.set_dir   = 1'b0;
    tif.lap       = 1'b0;
    step(2);
    chk("reset_disp", disp(), 0);
    chk("reset_running", tif.running, 0);
    chk("reset_done", tif.done, 0);
    chk("reset_tick", tif.tick, 0);
    chk("reset_state", dbg_state, 0);
    reset = 1'b0;
    step(1);

    // Stopwatch: 60 ticks, 10 cycles apart, reaching one minute.
    tif.mode   = 1'b0;
    t0         = tick_cnt;
    last_tick  = -1;
    spacing_on = 1'b1;
    tif.run    = 1'b1;
    step(601);
    tif.run = 1'b0;
    step(2);
    spacing_on = 1'b0;
    chk("sw_ticks", tick_cnt - t0, 60);
    chk("sw_disp", disp(), hms(60));
    chk("sw_done", tif.done, 0);
    chk("sw_hold_state", dbg_state, 2);
    do_clear();
    step(1);
    chk("clear_disp", disp(), 0);
    chk("clear_running", tif.running, 0);

    // Preset edit wrap-around.
    tif.mode = 1'b1;
    set_event(2'b00, 1'b0);
    chk("wrap_sec_dn", disp(), hms(59));
    set_event(2'b10, 1'b0);
    chk("wrap_hr_dn", disp(), {7'd99, 7'd0, 7'd59});
    set_event(2'b10, 1'b1);
    chk("wrap_hr_up", disp(), {7'd0, 7'd0, 7'd59});
    tif.mode = 1'b0;
    tif.run  = 1'b1;
    step(2);
    set_event(2'b00, 1'b1);
    tif.run   = 1'b0;
    tif.clear = 1'b1;
    step(1);
    tif.clear = 1'b0;
    tif.mode  = 1'b1;
    step(1);
    chk("set_in_run_ignored", disp(), {7'd0, 7'd0, 7'd59});

    // Random preset edit sequence against an arithmetic field model.
    pulse_reset();
    tif.mode = 1'b1;
    ps = 0; pm = 0; ph = 0;
    for (int i = 0; i < 8; i++) begin
      f = $urandom_range(0, 3);
      d = $urandom_range(0, 1);
      if (f == 0) ps = (ps + (d ? 1 : 59)) % 60;
      if (f == 1) pm = (pm + (d ? 1 : 59)) % 60;
      if (f == 2) ph = (ph + (d ? 1 : HOUR_MAX)) % (HOUR_MAX + 1);
      exp_q.push_back({7'(ph), 7'(pm), 7'(ps)});
      set_event(2'(f), 1'(d));
      chk("rand_preset", disp(), exp_q.pop_front());
    end

    // Countdown from 00:01:00.
    pulse_reset();
    tif.mode = 1'b1;
    set_event(2'b01, 1'b1);
    chk("cd_preset", disp(), hms(60));
    t0      = tick_cnt;
    tif.run = 1'b1;
    step(12);
    chk("cd_first", disp(), hms(59));
    step(589);
    chk("cd_done", tif.done, 1);
    chk("cd_running", tif.running, 0);
    step(1);
    chk("cd_zero", disp(), 0);
    chk("cd_ticks", tick_cnt - t0, 60);
    step(100);
    chk("cd_stay_zero", disp(), 0);
    chk("cd_stay_done", tif.done, 1);
    chk("cd_no_more_ticks", tick_cnt - t0, 60);
    tif.run = 1'b0;
    do_clear();
    step(1);
    chk("clear_done", tif.done, 0);

    // Countdown from a zero preset finishes with no tick.
    pulse_reset();
    tif.mode = 1'b1;
    t0       = tick_cnt;
    tif.run  = 1'b1;
    step(3);
    chk("zero_done", tif.done, 1);
    chk("zero_running", tif.running, 0);
    chk("zero_no_tick", tick_cnt - t0, 0);
    tif.run = 1'b0;
    do_clear();

    // Random short countdown: done exactly on the k-th tick.
    pulse_reset();
    tif.mode = 1'b1;
    k        = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) set_event(2'b00, 1'b1);
    chk("rcd_preset", disp(), hms(k));
    t0      = tick_cnt;
    tif.run = 1'b1;
    step(TP * k);
    chk("rcd_not_yet", tif.done, 0);
    step(1);
    chk("rcd_done", tif.done, 1);
    step(1);
    chk("rcd_zero", disp(), 0);
    chk("rcd_ticks", tick_cnt - t0, k);
    tif.run = 1'b0;
    do_clear();

    // Hold: run drops 4 cycles after a tick for 25 cycles.
    tif.mode = 1'b0;
    t0       = tick_cnt;
    tif.run  = 1'b1;
    step(11);
    step(3);
    tif.run = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      chk("hold_disp", disp(), hms(1));
      chk("hold_no_tick", tick_cnt - t0, 1);
    end
    tif.run = 1'b1;
    step(6);
    chk("resume_early", tif.tick, 0);
    step(1);
    chk("resume_tick", tif.tick, 1);
    tif.run = 1'b0;
    step(2);
    do_clear();

    // Random run/hold segments: ticks = total prescaler advances / TP.
    t0  = tick_cnt;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      n       = $urandom_range(3, 30);
      h       = $urandom_range(2, 12);
      tif.run = 1'b1;
      step(n);
      acc += n;
      tif.run = 1'b0;
      step(h);
      chk("seg_ticks", tick_cnt - t0, acc / TP);
      chk("seg_disp", disp(), hms(acc / TP));
    end
    do_clear();

    // Lap freeze while counting continues.
    tif.run = 1'b1;
    step(15);
    tif.lap = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("lap_frozen", disp(), hms(14 / TP));
    end
    tif.lap = 1'b0;
    step(1);
    chk("lap_release", disp(), hms(64 / TP));
    tif.run = 1'b0;
    step(1);
    do_clear();

    // Clear and run together in RUN: IDLE first, then restart from preset k.
    tif.mode = 1'b1;
    tif.run  = 1'b1;
    step(15);
    chk("prio_counting", disp(), hms(k - 1));
    tif.clear = 1'b1;
    step(1);
    chk("prio_idle_state", dbg_state, 0);
    chk("prio_idle_running", tif.running, 0);
    tif.clear = 1'b0;
    step(1);
    chk("prio_restart", tif.running, 1);
    step(1);
    chk("prio_reload", disp(), hms(k));

    // Asynchronous reset mid-countdown.
    step(5);
    reset = 1'b1;
    #2;
    chk("areset_disp", disp(), 0);
    chk("areset_running", tif.running, 0);
    chk("areset_done", tif.done, 0);
    chk("areset_tick", tif.tick, 0);
    tif.run = 1'b0;
    #1;
    reset = 1'b0;
    step(2);
    chk("areset_preset_lost", disp(), 0);
    chk("areset_state", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hms_timer_core.md
# hms_timer_core

Parametrised hours/minutes/seconds time base. It is built around a single state machine and supports two modes: stopwatch (count up) and countdown (count down from an editable preset). It generates its own tick from CLOCK_50, synchronises and edge-detects the raw set button internally, and provides a lap freeze and a sticky done flag. It replaces the separate stopwatch/timer logic in the board top and feeds the existing binary-to-BCD and 7-segment converters through its registered `seconds`, `minutes` and `hours` outputs.

## Interface
- `CLK_HZ`, default 50_000_000, input clock frequency in Hz.
- `TICK_HZ`, default 1, count rate. The prescaler terminal value is CLK_HZ/TICK_HZ-1, which must be ≥1.
- `HOUR_MAX`, default 99, highest hours value (≤127).
- `CLOCK_50`, input, 1 bit, system clock.
- `reset`, input, 1 bit, asynchronous, active-high.
- `clear`, input, 1 bit, synchronous clear to IDLE. The preset is kept.
- `mode`, input, 1 bit. 0 = stopwatch, 1 = countdown. Sampled only on IDLE→RUN.
- `run`, input, 1 bit, level. 1 = count, 0 = hold.
- `set_btn`, input, 1 bit, raw asynchronous button, active-high.
- `set_field`, input, 2 bits. 00 = seconds, 01 = minutes, 10 = hours, 11 = none.
- `set_dir`, input, 1 bit. 1 = increment, 0 = decrement.
- `lap`, input, 1 bit, level. While high, the display outputs are frozen.
- `seconds`, output, 7 bits, displayed seconds (0–59).
- `minutes`, output, 7 bits, displayed minutes (0–59).
- `hours`, output, 7 bits, displayed hours (0–HOUR_MAX).
- `running`, output, 1 bit, high in state RUN.
- `done`, output, 1 bit, countdown reached zero. Sticky until clear or reset.
- `tick`, output, 1 bit, one-cycle pulse each time the counter updates.

## Operation

**States**
- IDLE → RUN when run=1. On entry:
  - the counter loads the preset (mode=1) or 00:00:00 (mode=0);
  - `mode` is latched;
  - the prescaler is zeroed.
- RUN → HOLD when run=0.
- HOLD → RUN when run=1. The prescaler resumes from its held value.
- RUN → DONE when the countdown reaches 00:00:00.
- Countdown started with preset 00:00:00: RUN → DONE on the first cycle in RUN, with no tick.
- Any state → IDLE on clear. Clear has priority over every other input.

**Tick**
- The prescaler advances only in RUN.
- `tick` is asserted in the cycle the prescaler hits its terminal value; the prescaler then wraps to 0.
- The counter updates on that same edge.

**Stopwatch**
- Seconds 59→0 carries into minutes; minutes 59→0 carries into hours.
- Hours HOUR_MAX→0 wraps the whole counter to 00:00:00. The block stays in RUN and never sets `done`.

**Countdown**
- Seconds 0→59 borrows from minutes; minutes 0→59 borrows from hours.
- The tick that reaches 00:00:00 enters DONE: `done`=1, the counter holds at zero.

**Preset editing**
- Allowed only in IDLE.
- `set_btn` passes through a 2-FF synchroniser, and a rising-edge detector produces a one-cycle set event.
- A set event adjusts the selected preset field by ±1:
  - seconds and minutes wrap 59↔0;
  - hours wraps HOUR_MAX↔0;
  - field 11 has no effect.
- Set events outside IDLE are discarded.
- A set event in the same cycle as IDLE→RUN is discarded, and the unmodified preset is loaded.

**Display source**
- IDLE with mode=1: the preset.
- IDLE with mode=0: 00:00:00.
- Otherwise: the live counter.
- When `lap` rises, the outputs capture the current source value and hold it while lap=1; counting continues underneath. The outputs resume tracking the source in the cycle after lap falls.

**Widths**
- Each field is 7-bit unsigned. No intermediate value exceeds its field maximum.

## Timing
- Reset (asynchronous) takes effect immediately. Reset values:
  - state IDLE;
  - preset, counter, prescaler and synchroniser = 0;
  - `seconds`/`minutes`/`hours` = 0;
  - `running` = 0, `done` = 0, `tick` = 0.
- Reset mid-count aborts the count, and the preset is lost.
- Display outputs are registered with 1-cycle latency from their source.
- A set event reaches the preset 3 cycles after `set_btn` rises and is visible on the outputs 1 cycle later.
- A `run` change affects the state on the next edge. A tick in the same cycle that run falls is still applied.
- First tick after a start from IDLE comes CLK_HZ/TICK_HZ cycles after entering RUN.
- `running` and `done` are registered state decodes; they change in the same cycle as the state.
- `clear` takes effect on the next edge:
  - counter and prescaler go to 0, `done` to 0;
  - outputs show the IDLE source 1 cycle later.

## Test plan
All scenarios use bench parameters CLK_HZ=10, TICK_HZ=1, HOUR_MAX=99.
- **Stopwatch:** mode=0, run=1 for 600 cycles → 60 `tick` pulses spaced 10 cycles apart; outputs read 00:01:00; `done` stays 0.
- **Countdown:** one set event with field=01, dir=1 → preset 00:01:00. Then mode=1, run=1 → after the 1st tick the outputs read 00:00:59; after the 60th tick `done`=1, `running`=0, outputs 00:00:00, and they stay there for 100 more cycles.
- **Set wrap:** from reset, field=00, dir=0, one event → seconds 59. Field=10, dir=0 → hours 99. Field=10, dir=1 → hours 0. A set event while in RUN → preset unchanged.
- **Hold and lap:**
  - run drops 4 cycles after a tick and stays low for 25 cycles → no `tick` and outputs unchanged during the hold; the next tick comes 6 cycles after run rises.
  - lap=1 for 50 cycles → outputs frozen while the counter advances by 5; outputs jump to the live value 1 cycle after lap falls.
- **Priority and reset:**
  - clear and run asserted together in RUN → IDLE, then RUN on the following edge, with the counter restarting from the preset.
  - reset asserted mid-countdown between clock edges → all outputs 0 immediately; preset lost.
